// File: rtl/risc_v_multi_cycle_core.sv
// risc_v_multi_cycle_core: multi-cycle RV32I/RV32E core on a single shared req/ack memory port.
// Latency: branch 3, alu/lui/jal/sw 4, lw 5 cycles with zero-wait memory; +1 per ack wait cycle.
// Backpressure: mem_req_o with its address/we/wdata is held steady until mem_ack_i is sampled.
`timescale 1ns/1ps
module risc_v_multi_cycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32,
  parameter int          ADDR_W   = 32,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [31:0]       pc_o,
  output logic [2:0]        state_o,
  output logic              trap_o,
  output logic [CNT_W-1:0]  instret_o,
  input  logic [4:0]        dbg_sel_i,
  output logic [31:0]       dbg_data_o
);

  localparam int         RW   = $clog2(NUM_REGS);
  localparam logic [5:0] NREG = 6'(NUM_REGS);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT,
    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI,
    OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JAL
  } op_t;

  state_t             state;
  op_t                op;
  logic [31:0]        pc;
  logic [31:0]        ir;
  logic [31:0]        a;
  logic [31:0]        b;
  logic [31:0]        imm;
  logic [31:0]        alu_out;
  logic [31:0]        mdr;
  logic [4:0]         rd;
  logic [CNT_W-1:0]   instret;
  logic               trap;
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [31:0]        mem_wdata;
  logic [31:0]        regs [NUM_REGS];

  // instruction fields
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd_f;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign rd_f   = ir[11:7];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u  = {ir[31:12], 12'b0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // register reads; x0 and indices beyond the implemented file read as zero
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  assign rs1_val    = (rs1 == 5'd0 || {1'b0, rs1} >= NREG) ? 32'd0 : regs[rs1[RW-1:0]];
  assign rs2_val    = (rs2 == 5'd0 || {1'b0, rs2} >= NREG) ? 32'd0 : regs[rs2[RW-1:0]];
  assign dbg_data_o = (dbg_sel_i == 5'd0 || {1'b0, dbg_sel_i} >= NREG) ? 32'd0
                                                                      : regs[dbg_sel_i[RW-1:0]];

  op_t         dec_op;
  logic        dec_ok;
  logic [31:0] dec_imm;
  logic        use_rs1;
  logic        use_rs2;
  logic        use_rd;
  logic        reg_bad;

  // decode the fetched word into an operation, its immediate and the register fields it uses
  always_comb begin
    dec_op  = OP_ADD;
    dec_ok  = 1'b0;
    dec_imm = imm_i;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      7'b0110011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        if (funct7 == 7'b0000000 && funct3 == 3'b000) begin
          dec_op = OP_ADD; dec_ok = 1'b1;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_op = OP_SUB; dec_ok = 1'b1;
        end else if (funct7 == 7'b0000000 && funct3 == 3'b111) begin
          dec_op = OP_AND; dec_ok = 1'b1;
        end else if (funct7 == 7'b0000000 && funct3 == 3'b110) begin
          dec_op = OP_OR; dec_ok = 1'b1;
        end else if (funct7 == 7'b0000000 && funct3 == 3'b010) begin
          dec_op = OP_SLT; dec_ok = 1'b1;
        end
      end
      7'b0010011: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        case (funct3)
          3'b000:  begin dec_op = OP_ADDI; dec_ok = 1'b1; end
          3'b111:  begin dec_op = OP_ANDI; dec_ok = 1'b1; end
          3'b110:  begin dec_op = OP_ORI;  dec_ok = 1'b1; end
          default: dec_ok = 1'b0;
        endcase
      end
      7'b0110111: begin
        use_rd  = 1'b1;
        dec_op  = OP_LUI;
        dec_imm = imm_u;
        dec_ok  = 1'b1;
      end
      7'b0000011: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        dec_op  = OP_LW;
        dec_ok  = (funct3 == 3'b010);
      end
      7'b0100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_op  = OP_SW;
        dec_imm = imm_s;
        dec_ok  = (funct3 == 3'b010);
      end
      7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec_imm = imm_b;
        if (funct3 == 3'b000) begin
          dec_op = OP_BEQ; dec_ok = 1'b1;
        end else if (funct3 == 3'b001) begin
          dec_op = OP_BNE; dec_ok = 1'b1;
        end
      end
      7'b1101111: begin
        use_rd  = 1'b1;
        dec_op  = OP_JAL;
        dec_imm = imm_j;
        dec_ok  = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
    reg_bad = (use_rs1 && {1'b0, rs1}  >= NREG) ||
              (use_rs2 && {1'b0, rs2}  >= NREG) ||
              (use_rd  && {1'b0, rd_f} >= NREG);
  end

  logic [31:0] alu_res;
  logic [31:0] pc_plus4;
  logic [31:0] pc_target;
  logic        br_taken;
  logic [31:0] br_next;
  logic [31:0] wb_next;

  // ALU and next-PC candidates computed from the latched operands
  always_comb begin
    alu_res = 32'd0;
    case (op)
      OP_ADD:       alu_res = a + b;
      OP_SUB:       alu_res = a - b;
      OP_AND:       alu_res = a & b;
      OP_OR:        alu_res = a | b;
      OP_SLT:       alu_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_ADDI:      alu_res = a + imm;
      OP_ANDI:      alu_res = a & imm;
      OP_ORI:       alu_res = a | imm;
      OP_LUI:       alu_res = imm;
      OP_LW, OP_SW: alu_res = a + imm;
      OP_JAL:       alu_res = pc + 32'd4;
      default:      alu_res = 32'd0;
    endcase
    pc_plus4  = pc + 32'd4;
    pc_target = pc + imm;
    br_taken  = (op == OP_BEQ) ? (a == b) : (op == OP_BNE) ? (a != b) : 1'b0;
    br_next   = br_taken ? pc_target : pc_plus4;
    wb_next   = (op == OP_JAL) ? pc : pc_plus4;
  end

  // control FSM; memory outputs are registered and loaded on the transition into FETCH/MEM
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_FETCH;
      op        <= OP_ADD;
      pc        <= RESET_PC;
      ir        <= 32'd0;
      a         <= 32'd0;
      b         <= 32'd0;
      imm       <= 32'd0;
      alu_out   <= 32'd0;
      mdr       <= 32'd0;
      rd        <= 5'd0;
      instret   <= '0;
      trap      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!mem_req) begin
            // first fetch after reset: raise the request one cycle later
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc[ADDR_W-1:0];
          end else if (mem_ack_i) begin
            ir      <= mem_rdata_i;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a   <= rs1_val;
          b   <= rs2_val;
          imm <= dec_imm;
          op  <= dec_op;
          rd  <= rd_f;
          if (!dec_ok || reg_bad) begin
            trap  <= 1'b1;
            state <= S_TRAP;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          case (op)
            OP_LW, OP_SW: begin
              alu_out <= alu_res;
              if (alu_res[1:0] != 2'b00) begin
                trap  <= 1'b1;
                state <= S_TRAP;
              end else begin
                mem_req   <= 1'b1;
                mem_we    <= (op == OP_SW);
                mem_addr  <= alu_res[ADDR_W-1:0];
                mem_wdata <= b;
                state     <= S_MEM;
              end
            end
            OP_BEQ, OP_BNE: begin
              if (br_taken && pc_target[1]) begin
                trap  <= 1'b1;
                state <= S_TRAP;
              end else begin
                pc       <= br_next;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= br_next[ADDR_W-1:0];
                instret  <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
                state    <= S_FETCH;
              end
            end
            OP_JAL: begin
              if (pc_target[1]) begin
                trap  <= 1'b1;
                state <= S_TRAP;
              end else begin
                alu_out <= alu_res;
                pc      <= pc_target;
                state   <= S_WB;
              end
            end
            default: begin
              alu_out <= alu_res;
              state   <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ack_i) begin
            if (op == OP_LW) begin
              mdr     <= mem_rdata_i;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              state   <= S_WB;
            end else begin
              pc       <= pc_plus4;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc_plus4[ADDR_W-1:0];
              instret  <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
              state    <= S_FETCH;
            end
          end
        end
        S_WB: begin
          if (rd != 5'd0) regs[rd[RW-1:0]] <= (op == OP_LW) ? mdr : alu_out;
          pc       <= wb_next;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= wb_next[ADDR_W-1:0];
          instret  <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
          state    <= S_FETCH;
        end
        default: begin
          // TRAP: park with the bus idle until reset
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          trap    <= 1'b1;
        end
      endcase
    end
  end

  assign mem_req_o   = mem_req;
  assign mem_we_o    = mem_we;
  assign mem_addr_o  = mem_addr;
  assign mem_wdata_o = mem_wdata;
  assign pc_o        = pc;
  assign state_o     = state;
  assign trap_o      = trap;
  assign instret_o   = instret;

endmodule

// File: tb/tb_risc_v_multi_cycle_core.sv
// tb_risc_v_multi_cycle_core: directed program vectors against a wait-state memory model.
// Latency: measured per program from the first fetch cycle to the last retire.
// Backpressure: memory ack delayed by a configurable number of cycles per request.
`timescale 1ns/1ps
module tb_risc_v_multi_cycle_core;

  logic        clk;
  logic        reset;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic [31:0] pc_o;
  logic [2:0]  state_o;
  logic        trap_o;
  logic [31:0] instret_o;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_data;

  // RV32E instance fed a constant instruction
  logic        req16, we16, trap16;
  logic [31:0] addr16, wdata16, pc16, instret16, dbg16;
  logic [2:0]  state16;
  logic [4:0]  dbg_sel16;

  risc_v_multi_cycle_core #(.RESET_PC(32'h0), .NUM_REGS(32), .ADDR_W(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .pc_o(pc_o), .state_o(state_o), .trap_o(trap_o), .instret_o(instret_o),
    .dbg_sel_i(dbg_sel), .dbg_data_o(dbg_data)
  );

  risc_v_multi_cycle_core #(.RESET_PC(32'h0), .NUM_REGS(16), .ADDR_W(32), .CNT_W(32)) dut16 (
    .clk(clk), .reset(reset),
    .mem_req_o(req16), .mem_we_o(we16), .mem_addr_o(addr16),
    .mem_wdata_o(wdata16), .mem_rdata_i(32'h00208A33), .mem_ack_i(req16),
    .pc_o(pc16), .state_o(state16), .trap_o(trap16), .instret_o(instret16),
    .dbg_sel_i(dbg_sel16), .dbg_data_o(dbg16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: program words below 0x40, data RAM written only by the DUT
  logic [31:0] prog [16];
  logic [31:0] dmem [64];
  int          wait_cycles;
  int          wait_cnt;

  assign mem_ack_i   = mem_req_o && (wait_cnt >= wait_cycles);
  assign mem_rdata_i = (mem_addr_o[7:6] != 2'b00) ? dmem[mem_addr_o[7:2]] : prog[mem_addr_o[5:2]];

  always @(posedge clk) begin
    wait_cnt <= (mem_req_o && !mem_ack_i) ? wait_cnt + 1 : 0;
    if (mem_req_o && mem_ack_i && mem_we_o) dmem[mem_addr_o[7:2]] <= mem_wdata_o;
  end

  // bus stability monitor and loop-body fetch counter
  logic        stall_prev;
  logic [31:0] addr_prev, wd_prev;
  logic        we_prev;
  int          stab_err;
  int          stall_seen;
  int          body_cnt;

  always @(negedge clk) begin
    if (stall_prev && mem_req_o &&
        (mem_addr_o != addr_prev || mem_we_o != we_prev || mem_wdata_o != wd_prev))
      stab_err <= stab_err + 1;
    if (stall_prev && mem_req_o) stall_seen <= stall_seen + 1;
    stall_prev <= mem_req_o && !mem_ack_i;
    addr_prev  <= mem_addr_o;
    we_prev    <= mem_we_o;
    wd_prev    <= mem_wdata_o;
  end

  always @(posedge clk) begin
    if (!reset) body_cnt <= 0;
    else if (mem_req_o && mem_ack_i && !mem_we_o && mem_addr_o == 32'h4) body_cnt <= body_cnt + 1;
  end

  int tests;
  int failed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic rd_reg(input logic [4:0] r, output logic [31:0] v);
    dbg_sel = r;
    #1;
    v = dbg_data;
  endtask

  typedef struct {
    string       name;
    logic [31:0] w [8];
    int          wait_n;
    int          retire;
    int          cycles;
    logic [4:0]  r1;
    logic [31:0] v1;
    logic [4:0]  r2;
    logic [31:0] v2;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs [6];
  int   ret_cyc [16];

  // reset is already low on entry; release it and count cycles from the first fetch cycle
  task automatic run_prog(input int target, input int max_cyc, output int cyc);
    int c;
    for (int k = 0; k < 16; k++) ret_cyc[k] = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!mem_req_o && c < 10);
    c = 0;
    while (instret_o != 32'(target) && c < max_cyc) begin
      @(negedge clk);
      c++;
      ret_cyc[instret_o[3:0]] = (ret_cyc[instret_o[3:0]] == 0) ? c : ret_cyc[instret_o[3:0]];
    end
    cyc = c;
  endtask

  task automatic load(input logic [31:0] w [8]);
    for (int k = 0; k < 16; k++) prog[k] = (k < 8) ? w[k] : 32'h0;
  endtask

  initial begin
    logic [31:0] v;
    int          cyc;
    tests = 0; failed = 0;
    reset = 1'b0; dbg_sel = 5'd0; dbg_sel16 = 5'd20; wait_cycles = 0;
    stab_err = 0; stall_seen = 0; stall_prev = 1'b0;
    for (int k = 0; k < 16; k++) prog[k] = 32'h0;

    vecs[0] = '{"add_zw",  '{32'h00500093, 32'h00700113, 32'h002081B3, 0, 0, 0, 0, 0},
                0, 3, 12, 5'd3, 32'd12, 5'd2, 32'd7, 32'd12};
    vecs[1] = '{"add_w3",  '{32'h00500093, 32'h00700113, 32'h002081B3, 0, 0, 0, 0, 0},
                3, 3, 21, 5'd3, 32'd12, 5'd1, 32'd5, 32'd12};
    vecs[2] = '{"sw_lw",   '{32'h04000293, 32'h0052A423, 32'h0082A303, 0, 0, 0, 0, 0},
                0, 3, 13, 5'd6, 32'h40, 5'd5, 32'h40, 32'd12};
    vecs[3] = '{"loop",    '{32'h00300093, 32'hFFF08093, 32'hFE009EE3, 0, 0, 0, 0, 0},
                0, 7, 25, 5'd1, 32'd0, 5'd0, 32'd0, 32'd12};
    vecs[4] = '{"lui_slt", '{32'h800003B7, 32'h00100413, 32'h0083A4B3, 32'h40740533, 0, 0, 0, 0},
                0, 4, 16, 5'd9, 32'd1, 5'd10, 32'h80000001, 32'd16};
    vecs[5] = '{"br_jal",  '{32'h0F000093, 32'h00F0E113, 32'h03C17193, 32'h00318463,
                            32'h00100213, 32'h008002EF, 32'h00100213, 32'h0030E333},
                1, 6, 29, 5'd6, 32'hFC, 5'd5, 32'd24, 32'd32};

    // reset state
    repeat (2) @(negedge clk);
    check("reset_req", {31'b0, mem_req_o}, 32'd0);
    check("reset_we", {31'b0, mem_we_o}, 32'd0);
    check("reset_pc", pc_o, 32'h0);
    check("reset_state", {29'b0, state_o}, 32'd0);
    check("reset_instret", instret_o, 32'd0);

    for (int i = 0; i < 6; i++) begin
      reset = 1'b0;
      wait_cycles = vecs[i].wait_n;
      load(vecs[i].w);
      run_prog(vecs[i].retire, 200, cyc);
      check({vecs[i].name, "_cycles"}, 32'(cyc), 32'(vecs[i].cycles));
      check({vecs[i].name, "_instret"}, instret_o, 32'(vecs[i].retire));
      check({vecs[i].name, "_pc"}, pc_o, vecs[i].pc);
      rd_reg(vecs[i].r1, v);
      check({vecs[i].name, "_r1"}, v, vecs[i].v1);
      rd_reg(vecs[i].r2, v);
      check({vecs[i].name, "_r2"}, v, vecs[i].v2);
      if (i == 2) begin
        check("lw_latency", 32'(ret_cyc[3] - ret_cyc[2]), 32'd5);
        check("mem_0x48", dmem[18], 32'h40);
      end
      if (i == 3) check("loop_body", 32'(body_cnt), 32'd3);
      if (i == 5) begin
        rd_reg(5'd4, v);
        check("br_skip_x4", v, 32'd0);
      end
    end
    check("bus_stable", 32'(stab_err), 32'd0);
    check("stalls_seen", {31'b0, stall_seen > 0}, 32'd1);

    // unaligned load traps without architectural side effects
    reset = 1'b0;
    wait_cycles = 0;
    load('{32'h00500093, 32'h00102083, 0, 0, 0, 0, 0, 0});
    run_prog(1, 50, cyc);
    repeat (10) @(negedge clk);
    check("trap_flag", {31'b0, trap_o}, 32'd1);
    check("trap_state", {29'b0, state_o}, 32'd7);
    check("trap_req", {31'b0, mem_req_o}, 32'd0);
    check("trap_instret", instret_o, 32'd1);
    check("trap_pc", pc_o, 32'd4);
    rd_reg(5'd1, v);
    check("trap_x1", v, 32'd5);

    // reset while a fetch is stalled
    reset = 1'b0;
    wait_cycles = 1000;
    load(vecs[0].w);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("stall_req", {31'b0, mem_req_o}, 32'd1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_stall_req", {31'b0, mem_req_o}, 32'd0);
    check("rst_stall_trap", {31'b0, trap_o}, 32'd0);
    check("rst_stall_pc", pc_o, 32'h0);
    wait_cycles = 0;
    reset = 1'b1;
    @(negedge clk);
    check("resume_req", {31'b0, mem_req_o}, 32'd1);
    check("resume_addr", mem_addr_o, 32'h0);
    cyc = 0;
    while (instret_o != 32'd3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    rd_reg(5'd3, v);
    check("resume_x3", v, 32'd12);
    check("resume_cycles", 32'(cyc), 32'd12);

    // RV32E instance: x20 destination is illegal
    check("e_trap", {31'b0, trap16}, 32'd1);
    check("e_state", {29'b0, state16}, 32'd7);
    check("e_instret", instret16, 32'd0);
    check("e_dbg_oob", dbg16, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/risc_v_multi_cycle_core.md
Name: risc_v_multi_cycle_core

Overview:
- Parametrised multi-cycle RV32I/RV32E core. It is the successor to the single-cycle top and executes one instruction over 3-5 states from a control FSM.
- All instruction fetches and data accesses go through one shared memory port with a req/ack handshake, so memories with wait states are supported.
- Includes an internal register file, an ALU, a retired-instruction counter, and a debug register read port for benches.
- Supported instructions: add, sub, and, or, slt, addi, andi, ori, lui, lw, sw, beq, bne, jal.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NUM_REGS, 32, register count. Legal values are 32 (RV32I) or 16 (RV32E).
- ADDR_W, 32, width of mem_addr_o. The byte address is truncated to this width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_req_o  out  1  memory request. Held high until ack is sampled.
- mem_we_o  out  1  1 = store, 0 = fetch or load.
- mem_addr_o  out  ADDR_W  byte address. Always word-aligned when mem_req_o=1.
- mem_wdata_o  out  32  store data.
- mem_rdata_i  in  32  read data, valid in the cycle mem_ack_i=1.
- mem_ack_i  in  1  completion. May be high in the same cycle as mem_req_o.
- pc_o  out  32  current PC.
- state_o  out  3  FSM state encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=7.
- trap_o  out  1  sticky fault flag.
- instret_o  out  CNT_W  retired-instruction count.
- dbg_sel_i  in  5  debug register index.
- dbg_data_o  out  32  combinational read of x[dbg_sel_i]. Returns 0 for x0 or an index >= NUM_REGS.

Behaviour:
- Reset (reset=0 sampled at a clock edge):
  - PC=RESET_PC, state=FETCH, all registers=0, instret=0, trap_o=0.
  - mem_req_o=0 and mem_we_o=0 in the cycle after the reset edge.
  - Reset during a pending request abandons it. Any late ack is ignored because the FSM is back in FETCH with a fresh request.
- FETCH: mem_req_o=1, mem_we_o=0, mem_addr_o=PC. When mem_ack_i=1, IR<=mem_rdata_i and the FSM goes to DECODE. Otherwise it stays in FETCH with outputs stable.
- DECODE:
  - Latch A=x[rs1], B=x[rs2], and the sign-extended immediate (I/S/B/U/J formats).
  - Unknown opcode or funct combination -> TRAP.
  - With NUM_REGS=16, any rs1/rs2/rd index >= 16 -> TRAP.
  - Otherwise the FSM goes to EXECUTE.
- EXECUTE:
  - R/I-type: ALUOut<=result, go to WB.
  - lui: ALUOut<=imm, go to WB.
  - lw/sw: ALUOut<=A+imm. If ALUOut[1:0]!=0 -> TRAP, else go to MEM.
  - beq/bne: if the condition is true, PC<=PC+imm, else PC<=PC+4. Then go to FETCH and retire. A taken target with bit[1]!=0 -> TRAP and PC is unchanged.
  - jal: ALUOut<=PC+4, PC<=PC+imm (same alignment check), go to WB.
- MEM: mem_req_o=1, mem_addr_o=ALUOut, and for sw mem_we_o=1 with mem_wdata_o=B.
  - On ack: lw latches MDR<=mem_rdata_i and goes to WB.
  - On ack: sw sets PC<=PC+4, retires, and goes to FETCH.
- WB: x[rd]<=(lw ? MDR : ALUOut). Writes to x0 are discarded. Non-jal instructions set PC<=PC+4. Then retire and go to FETCH.
- Retire: instret increments by 1 and wraps modulo 2^CNT_W.
- TRAP: trap_o=1 and mem_req_o=0. The FSM holds until reset. No register or PC update happens on the faulting instruction.
- Arithmetic:
  - All ALU operations are 32-bit modulo 2^32; overflow is ignored.
  - slt is a signed compare.
  - PC wraps modulo 2^32.
- Latency with zero-wait memory (ack in the same cycle as req): branch 3 cycles; R/I/lui/jal/sw 4 cycles; lw 5 cycles. Each wait cycle on ack adds one cycle.
- mem_addr_o, mem_we_o and mem_wdata_o stay constant while mem_req_o=1 and ack=0.

Test Plan:
- Zero-wait memory. Program: addi x1,x0,5; addi x2,x0,7; add x3,x1,x2. After 12 cycles: x3=12, instret=3, pc_o=12.
- Memory ack delayed 3 cycles on every request. Run the same program. Required: 21 cycles total, and mem_addr_o stable during every wait.
- Program: addi x5,x0,0x40; sw x5,8(x5); lw x6,8(x5). Required: memory word 0x48 = 0x40, x6=0x40, and lw takes 5 cycles.
- Loop: addi x1,x0,3; addi x1,x1,-1; bne x1,x0,-4. Required: loop body runs 3 times, x1=0, instret=7.
- Unaligned lw x1,1(x0) -> trap_o=1 and state_o=7. x1 is unchanged, mem_req_o stays 0, and instret is frozen.
- Assert reset while a fetch is stalled. Required: the next cycle has mem_req_o=0, then FETCH resumes at RESET_PC with trap_o=0. With NUM_REGS=16, add x20,x1,x2 traps.
